// File: rtl/conv_frame_loader_if.sv
// conv_frame_loader_if: byte stream in, assembled image/kernel frame out
interface conv_frame_loader_if #(
    parameter int IMG_N = 25,
    parameter int KER_N = 9
);
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       keep_kernel;
    logic [7:0] image [IMG_N];
    logic [7:0] kernel [KER_N];
    logic       out_valid;
    logic       out_ack;
    logic       frame_err;
    modport master (
        output s_valid, s_data, s_last, keep_kernel, out_ack,
        input  s_ready, image, kernel, out_valid, frame_err
    );
    modport slave (
        input  s_valid, s_data, s_last, keep_kernel, out_ack,
        output s_ready, image, kernel, out_valid, frame_err
    );
endinterface

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: assembles kernel+image bytes into a held frame for the convolution stage
module conv_frame_loader #(
    parameter int IMG_N = 25,
    parameter int KER_N = 9
) (
    input logic clk,
    input logic rst,
    conv_frame_loader_if.slave bus
);
    localparam int CW = IMG_N > 1 ? $clog2(IMG_N) : 1;
    localparam int KW = KER_N > 1 ? $clog2(KER_N) : 1;
    typedef enum logic [1:0] {LOAD_K, LOAD_I, HOLD} state_t;
    state_t state;
    logic [CW-1:0] kcnt, icnt;
    logic [7:0] img_q [IMG_N];
    logic [7:0] ker_q [KER_N];
    logic s_ready_q, out_valid_q, frame_err_q;
    logic xfer, k_end, i_end;
    assign xfer  = bus.s_valid & s_ready_q;
    assign k_end = kcnt == CW'(KER_N - 1);
    assign i_end = icnt == CW'(IMG_N - 1);
    assign bus.s_ready   = s_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.image     = img_q;
    assign bus.kernel    = ker_q;
    // frame FSM: kernel bytes, then image bytes, then hold until acknowledged; framing errors restart at LOAD_K
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD_K;
            kcnt        <= '0;
            icnt        <= '0;
            s_ready_q   <= 1'b1;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < IMG_N; i++) img_q[i] <= '0;
            for (int i = 0; i < KER_N; i++) ker_q[i] <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                LOAD_K: if (xfer) begin
                    ker_q[kcnt[KW-1:0]] <= bus.s_data;
                    if (bus.s_last) begin
                        frame_err_q <= 1'b1;
                        kcnt        <= '0;
                        icnt        <= '0;
                    end else if (k_end) begin
                        kcnt  <= '0;
                        state <= LOAD_I;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                LOAD_I: if (xfer) begin
                    img_q[icnt] <= bus.s_data;
                    if (i_end && bus.s_last) begin
                        state       <= HOLD;
                        s_ready_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        kcnt        <= '0;
                        icnt        <= '0;
                    end else if (i_end || bus.s_last) begin
                        state       <= LOAD_K;
                        frame_err_q <= 1'b1;
                        kcnt        <= '0;
                        icnt        <= '0;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                HOLD: if (bus.out_ack) begin
                    state       <= bus.keep_kernel ? LOAD_I : LOAD_K;
                    s_ready_q   <= 1'b1;
                    out_valid_q <= 1'b0;
                    kcnt        <= '0;
                    icnt        <= '0;
                end
                default: state <= LOAD_K;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_loader.sv
// tb_conv_frame_loader: randomized frames checked against a byte-queue model of the loader
module tb_conv_frame_loader;
    localparam int IMG_N = 25;
    localparam int KER_N = 9;
    localparam int FULL  = IMG_N + KER_N;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [7:0] mk [KER_N];
    logic [7:0] mi [IMG_N];
    logic [7:0] tx_q [$];
    bit gaps;
    conv_frame_loader_if #(.IMG_N(IMG_N), .KER_N(KER_N)) bus ();
    conv_frame_loader #(.IMG_N(IMG_N), .KER_N(KER_N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // drive tx_q as one frame, s_last on index last_at (-1: never); returns one cycle after the final transfer
    task automatic push_frame(input int last_at);
        for (int n = 0; n < tx_q.size(); n++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                bus.s_last  = 1'($urandom);
            end
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = tx_q[n];
            bus.s_last  = (n == last_at);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // model: a good frame is kernel bytes first (when expected) followed by image bytes, in order
    task automatic model_load(input bit with_k);
        int off;
        off = with_k ? KER_N : 0;
        if (with_k) for (int j = 0; j < KER_N; j++) mk[j] = tx_q[j];
        for (int j = 0; j < IMG_N; j++) mi[j] = tx_q[off + j];
    endtask

    task automatic fill_rand(input int n);
        tx_q.delete();
        for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
    endtask

    task automatic ack(input bit keep);
        @(negedge clk);
        bus.out_ack     = 1'b1;
        bus.keep_kernel = keep;
        @(negedge clk);
        bus.out_ack     = 1'b0;
        bus.keep_kernel = 1'($urandom);
    endtask

    task automatic test_reset;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.out_ack = 1'b0; bus.keep_kernel = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b want=1", bus.s_ready); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== 8'h00) begin failures++; $display("FAIL reset_kernel[%0d] got=%h want=00", j, bus.kernel[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== 8'h00) begin failures++; $display("FAIL reset_image[%0d] got=%h want=00", j, bus.image[j]); end end
        rst = 1'b0;
    endtask

    task automatic test_full_frame;
        tx_q.delete();
        for (int j = 1; j <= FULL; j++) tx_q.push_back(8'(j));
        gaps = 0;
        push_frame(FULL - 1);
        model_load(1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid got=%b want=1", bus.out_valid); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b want=0", bus.s_ready); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL full_frame_err got=%b want=0", bus.frame_err); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL full_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL full_image[%0d] got=%h want=%h", j, bus.image[j], mi[j]); end end
    endtask

    task automatic test_backpressure;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cycle %0d got=%b want=1", c, bus.out_valid); end
            checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready cycle %0d got=%b want=0", c, bus.s_ready); end
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            bus.s_last  = 1'($urandom);
            bus.out_ack = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL bp_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL bp_image[%0d] got=%h want=%h", j, bus.image[j], mi[j]); end end
        ack(0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_ack_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_ack_s_ready got=%b want=1", bus.s_ready); end
        tx_q.delete();
        for (int j = 1; j <= FULL; j++) tx_q.push_back(8'(j));
        gaps = 1;
        push_frame(FULL - 1);
        model_load(1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_reload_out_valid got=%b want=1", bus.out_valid); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL bp_reload_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
    endtask

    task automatic test_kernel_reuse;
        ack(1);
        tx_q.delete();
        for (int j = 0; j < IMG_N; j++) tx_q.push_back(8'hFF);
        push_frame(IMG_N - 1);
        model_load(0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL reuse_out_valid got=%b want=1", bus.out_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reuse_frame_err got=%b want=0", bus.frame_err); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== 8'(j + 1)) begin failures++; $display("FAIL reuse_kernel[%0d] got=%h want=%h", j, bus.kernel[j], 8'(j + 1)); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== 8'hFF) begin failures++; $display("FAIL reuse_image[%0d] got=%h want=ff", j, bus.image[j]); end end
    endtask

    task automatic test_early_last;
        ack(0);
        fill_rand(5);
        push_frame(4);
        checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL early_frame_err got=%b want=1", bus.frame_err); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL early_out_valid got=%b want=0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL early_err_pulse_width got=%b want=0", bus.frame_err); end
        fill_rand(FULL);
        push_frame(FULL - 1);
        model_load(1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL early_next_out_valid got=%b want=1", bus.out_valid); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL early_next_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL early_next_image[%0d] got=%h want=%h", j, bus.image[j], mi[j]); end end
    endtask

    task automatic test_missing_last;
        ack(0);
        fill_rand(FULL);
        push_frame(-1);
        checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL missing_frame_err got=%b want=1", bus.frame_err); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL missing_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL missing_s_ready got=%b want=1", bus.s_ready); end
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL missing_err_pulse_width got=%b want=0", bus.frame_err); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL missing_out_valid_late got=%b want=0", bus.out_valid); end
        fill_rand(FULL);
        push_frame(FULL - 1);
        model_load(1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL missing_next_out_valid got=%b want=1", bus.out_valid); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL missing_next_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL missing_next_image[%0d] got=%h want=%h", j, bus.image[j], mi[j]); end end
    endtask

    task automatic test_reset_mid_frame;
        ack(0);
        fill_rand(20);
        push_frame(-1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err got=%b want=0", bus.frame_err); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== 8'h00) begin failures++; $display("FAIL midrst_kernel[%0d] got=%h want=00", j, bus.kernel[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== 8'h00) begin failures++; $display("FAIL midrst_image[%0d] got=%h want=00", j, bus.image[j]); end end
        rst = 1'b0;
        fill_rand(FULL);
        push_frame(FULL - 1);
        model_load(1);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_next_out_valid got=%b want=1", bus.out_valid); end
        for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL midrst_next_kernel[%0d] got=%h want=%h", j, bus.kernel[j], mk[j]); end end
        for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL midrst_next_image[%0d] got=%h want=%h", j, bus.image[j], mi[j]); end end
    endtask

    // random mix of good, early-last and missing-last frames with random kernel reuse
    task automatic test_random;
        bit in_hold, expect_k, keep;
        int len, kind, p;
        in_hold  = 1;
        expect_k = 1;
        gaps     = 1;
        for (int it = 0; it < 40; it++) begin
            if (in_hold) begin
                keep = 1'($urandom);
                ack(keep);
                expect_k = !keep;
                in_hold  = 0;
            end
            len  = expect_k ? FULL : IMG_N;
            kind = $urandom_range(5);
            if (kind == 0) begin
                p = $urandom_range(len - 2, 0);
                fill_rand(p + 1);
                push_frame(p);
            end else if (kind == 1) begin
                fill_rand(len);
                push_frame(-1);
            end else begin
                fill_rand(len);
                push_frame(len - 1);
            end
            if (kind < 2) begin
                checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL rand%0d_frame_err got=%b want=1", it, bus.frame_err); end
                checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rand%0d_err_out_valid got=%b want=0", it, bus.out_valid); end
                expect_k = 1;
            end else begin
                model_load(expect_k);
                checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rand%0d_out_valid got=%b want=1", it, bus.out_valid); end
                checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL rand%0d_frame_err got=%b want=0", it, bus.frame_err); end
                for (int j = 0; j < KER_N; j++) begin checks++; if (bus.kernel[j] !== mk[j]) begin failures++; $display("FAIL rand%0d_kernel[%0d] got=%h want=%h", it, j, bus.kernel[j], mk[j]); end end
                for (int j = 0; j < IMG_N; j++) begin checks++; if (bus.image[j] !== mi[j]) begin failures++; $display("FAIL rand%0d_image[%0d] got=%h want=%h", it, j, bus.image[j], mi[j]); end end
                in_hold = 1;
            end
        end
    endtask

    initial begin
        gaps = 0;
        test_reset;
        test_full_frame;
        test_backpressure;
        test_kernel_reuse;
        test_early_last;
        test_missing_last;
        test_reset_mid_frame;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_frame_loader.md
CONV_FRAME_LOADER -- requirements
Module: conv_frame_loader

Interface
REQ-001 SHALL have parameter IMG_N, default 25: number of image pixels per frame (5x5, row-major).
REQ-002 SHALL have parameter KER_N, default 9: number of kernel coefficients per frame (3x3, row-major).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1: input byte present.
REQ-006 SHALL have port s_ready, output, 1: loader accepts a byte this cycle.
REQ-007 SHALL have port s_data, input, 8: input byte (unsigned).
REQ-008 SHALL have port s_last, input, 1: marks the final byte of a frame.
REQ-009 SHALL have port keep_kernel, input, 1: sampled on out_ack; when high, the next frame omits the kernel.
REQ-010 SHALL have port image, output, 8 x IMG_N array: assembled image for the downstream convolution stage.
REQ-011 SHALL have port kernel, output, 8 x KER_N array: assembled kernel.
REQ-012 SHALL have port out_valid, output, 1: image and kernel are complete and stable.
REQ-013 SHALL have port out_ack, input, 1: downstream has consumed the frame.
REQ-014 SHALL have port frame_err, output, 1: single-cycle pulse on a framing error.

Function
REQ-015 SHALL implement the states LOAD_K, LOAD_I and HOLD.
REQ-016 SHALL treat a byte as transferred only on a cycle where s_valid and s_ready are both high.
REQ-017 SHALL drive s_ready high in LOAD_K and LOAD_I, and low in HOLD.
REQ-018 In LOAD_K, SHALL write the transferred byte to kernel[kcnt] and increment kcnt (0..KER_N-1).
- On the KER_N-th byte: go to LOAD_I.
REQ-019 In LOAD_I, SHALL write the transferred byte to image[icnt] and increment icnt (0..IMG_N-1).
- On the IMG_N-th byte: go to HOLD.
REQ-020 SHALL write image and kernel registers only on transfers; they SHALL remain unchanged at all other times, and throughout HOLD.
REQ-021 SHALL drive out_valid high exactly while in HOLD.
- First out_valid cycle is the cycle after the final transfer (latency 1).
REQ-022 In HOLD, out_ack high SHALL clear both counters and select the next state:
- keep_kernel=1: go to LOAD_I, retaining the kernel registers.
- keep_kernel=0: go to LOAD_K.
REQ-023 SHALL ignore out_ack outside HOLD.
REQ-024 SHALL ignore s_valid, s_data and s_last while s_ready is low (HOLD).
REQ-025 SHALL treat s_last high on any transfer other than the final byte of the expected frame as an early-last error.
- Expected frame: KER_N+IMG_N bytes from LOAD_K; IMG_N bytes when entered via keep_kernel.
REQ-026 SHALL treat s_last low on the final expected byte as a missing-last error.
REQ-027 On either framing error, SHALL:
- pulse frame_err for exactly one cycle, the cycle after the offending transfer;
- clear both counters;
- go to LOAD_K, not HOLD.
REQ-028 After a framing error, SHALL leave partially written image and kernel contents undefined; out_valid SHALL stay low until a complete, correctly framed frame has been loaded.
REQ-029 A frame that ends with a missing-last error SHALL NOT assert out_valid; the loader SHALL NOT resynchronise by searching for the next s_last.
REQ-030 SHALL size both counters to hold values up to IMG_N-1 without wrap.
- Counters SHALL never exceed their bound.
- An index beyond the array SHALL never be written.
REQ-031 When a transfer and out_ack occur in the same cycle in HOLD, SHALL act on out_ack only (s_ready is low, so no transfer exists).

Reset
REQ-032 On rst high at a clock edge, SHALL set:
- state = LOAD_K, kcnt = 0, icnt = 0;
- out_valid = 0, frame_err = 0;
- s_ready = 1 from the first cycle after reset release.
REQ-033 On reset, SHALL clear all image and kernel registers to 0.
REQ-034 SHALL give rst priority over every other input, including mid-frame and during HOLD; a partial frame SHALL be discarded.

Verification
REQ-035 Full frame: send 34 bytes with values 1..34 and s_last on byte 34 -> kernel[0..8]=1..9, image[0..24]=10..34; out_valid rises the next cycle; s_ready=0.
REQ-036 Backpressure: hold HOLD for 20 cycles with s_valid=1 and changing s_data -> arrays unchanged, out_valid=1 throughout; out_ack=1, keep_kernel=0 -> out_valid=0 and s_ready=1 the next cycle, state LOAD_K.
REQ-037 Kernel reuse: out_ack with keep_kernel=1, then send 25 bytes of 0xFF with s_last on byte 25 -> kernel still 1..9, all image=0xFF, out_valid=1.
REQ-038 Early last: s_last on byte 5 of a frame -> frame_err pulses 1 cycle, out_valid stays 0; the following correct 34-byte frame loads normally.
REQ-039 Missing last: 34 bytes with s_last=0 -> frame_err pulse, no out_valid; loader back in LOAD_K with counters 0.
REQ-040 Reset mid-frame: assert rst after byte 20 -> the cycle after the rst edge shows all outputs 0 and out_valid=0; a fresh 34-byte frame completes correctly.
